// File: rtl/alu4_pkg.sv
// alu4_pkg: shared opcodes, widths and sequencer state type for the 4-bit ALU issue path
package alu4_pkg;

    localparam int ALU_W   = 4;
    localparam int RF_AW   = 2;
    localparam int OPCNT_W = 8;

    localparam logic [3:0] OP_ORR  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_NAND = 4'b0100;
    localparam logic [3:0] OP_XNOR = 4'b0101;
    localparam logic [3:0] OP_ANDN = 4'b0110;
    localparam logic [3:0] OP_ORN  = 4'b0111;
    localparam logic [3:0] OP_INC  = 4'b1000;
    localparam logic [3:0] OP_DEC  = 4'b1001;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_NOT  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

endpackage

// File: rtl/alu4_regfile.sv
// alu4_regfile: operand register file with two async read ports and one sync write port
module alu4_regfile
    import alu4_pkg::*;
#(
    parameter int W    = ALU_W,
    parameter int RA_W = RF_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] ra1,
    input  logic [RA_W-1:0] ra2,
    output logic [W-1:0]    rd1,
    output logic [W-1:0]    rd2,
    input  logic            we,
    input  logic [RA_W-1:0] wa,
    input  logic [W-1:0]    wd
);

    logic [W-1:0] rf_q [2**RA_W];
    logic [W-1:0] rf_d [2**RA_W];

    assign rd1 = rf_q[ra1];
    assign rd2 = rf_q[ra2];

    // next register contents: single write port
    always_comb begin
        rf_d = rf_q;
        if (we) rf_d[wa] = wd;
    end

    // register storage, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) rf_q <= '{default: '0};
        else     rf_q <= rf_d;
    end

endmodule

// File: rtl/alu4_issue_ctrl.sv
// alu4_issue_ctrl: command sequencer driving the 4-bit ALU and returning results on a response stream
module alu4_issue_ctrl
    import alu4_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int RA_W  = RF_AW,
    parameter int CNT_W = OPCNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [3:0]       cmd_opcode,
    input  logic [RA_W-1:0]  cmd_rd,
    input  logic [RA_W-1:0]  cmd_rs1,
    input  logic [RA_W-1:0]  cmd_rs2,
    input  logic [W-1:0]     cmd_imm,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic [3:0]       opcode,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_x,
    output logic [W-1:0]     rsp_y,
    output logic [W-1:0]     hi,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic [W-1:0]     rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, rsp_done, in_issue;
    logic             rf_we;
    logic [RA_W-1:0]  rf_wa;
    logic [W-1:0]     rf_wd, rs1_val, rs2_val;

    assign accept   = cmd_valid & cmd_ready;
    assign rsp_done = rsp_valid & rsp_ready;
    assign in_issue = state_q == ISSUE;

    // the ISSUE-cycle capture shares the single write port with immediate loads
    assign rf_we = (accept & cmd_load) | in_issue;
    assign rf_wa = in_issue ? rd_q : cmd_rd;
    assign rf_wd = in_issue ? x : cmd_imm;

    alu4_regfile #(.W(W), .RA_W(RA_W)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (cmd_rs1),
        .ra2 (cmd_rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state: loads skip ISSUE, ALU ops spend exactly one cycle there
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = cmd_load ? RESP : ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs decoded purely from state, so ready never depends on valid
    always_comb begin
        cmd_ready = state_q == IDLE;
        rsp_valid = state_q == RESP;
    end

    // datapath next values: operands on accept, result capture in ISSUE, count on handshake
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        rsp_x_d  = rsp_x_q;
        rsp_y_d  = rsp_y_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        if (accept && !cmd_load) begin
            a_d      = rs1_val;
            b_d      = rs2_val;
            opcode_d = cmd_opcode;
            rd_d     = cmd_rd;
        end
        if (accept && cmd_load) begin
            rsp_x_d = cmd_imm;
            rsp_y_d = '0;
        end
        if (in_issue) begin
            rsp_x_d = x;
            rsp_y_d = y;
            hi_d    = y;
        end
        if (rsp_done) cnt_d = cnt_q + CNT_W'(1);
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= '0;
            rd_q     <= '0;
            rsp_x_q  <= '0;
            rsp_y_q  <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            rsp_x_q  <= rsp_x_d;
            rsp_y_q  <= rsp_y_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign opcode   = opcode_q;
    assign rsp_x    = rsp_x_q;
    assign rsp_y    = rsp_y_q;
    assign hi       = hi_q;
    assign op_count = cnt_q;

endmodule

// File: tb/tb_alu4_issue_ctrl.sv
// tb_alu4_issue_ctrl: directed-vector bench for the ALU issue sequencer with a behavioural ALU
module tb_alu4_issue_ctrl;
    import alu4_pkg::*;

    logic       clk = 0;
    logic       rst = 1;
    logic       cmd_valid = 0, cmd_load = 0, rsp_ready = 0;
    logic [3:0] cmd_opcode = 0, cmd_imm = 0;
    logic [1:0] cmd_rd = 0, cmd_rs1 = 0, cmd_rs2 = 0;
    logic       cmd_ready, rsp_valid;
    logic [3:0] a, b, opcode, x, y, rsp_x, rsp_y, hi;
    logic [7:0] op_count;
    logic [7:0] alu_res;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu4_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_opcode (cmd_opcode),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .x          (x),
        .y          (y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_x      (rsp_x),
        .rsp_y      (rsp_y),
        .hi         (hi),
        .op_count   (op_count)
    );

    // behavioural stand-in for the 4-bit ALU: {y,x} is the 8-bit result
    always_comb begin
        alu_res = 8'h00;
        case (opcode)
            OP_ORR:  alu_res = {4'h0, a | b};
            OP_ADD:  alu_res = {4'h0, a} + {4'h0, b};
            OP_SUB:  alu_res = {4'h0, a - b};
            OP_MUL:  alu_res = {4'h0, a} * {4'h0, b};
            OP_SHL:  alu_res = {4'h0, a} << b;
            OP_SHR:  alu_res = {a, 4'h0} >> b;
            default: alu_res = 8'h00;
        endcase
    end
    assign x = alu_res[3:0];
    assign y = alu_res[7:4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic send(input logic ld, input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [3:0] imm);
        cmd_load = ld; cmd_opcode = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1;
        for (int n = 0; n < 20 && !cmd_ready; n++) begin
            @(posedge clk); #1;
        end
        if (!cmd_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic await_rsp(input string tag, input int lat, output logic [3:0] rx, output logic [3:0] ry);
        int n = 1;
        while (!rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        rx = rsp_x;
        ry = rsp_y;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic load(input logic [1:0] rd, input logic [3:0] imm);
        logic [3:0] rx, ry;
        send(1, 0, rd, 0, 0, imm);
        await_rsp("load", 1, rx, ry);
        chk("load_x", rx, imm);
        chk("load_y", ry, 0);
    endtask

    task automatic alu_op(input string tag, input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [3:0] ex, input logic [3:0] ey);
        logic [3:0] rx, ry;
        send(0, op, rd, rs1, rs2, 0);
        await_rsp(tag, 2, rx, ry);
        chk({tag, "_x"}, rx, ex);
        chk({tag, "_y"}, ry, ey);
    endtask

    initial begin
        int seen, acc;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_rsp_x", rsp_x, 0);
        chk("rst_hi", hi, 0);
        chk("rst_op_count", op_count, 0);

        load(0, 9);
        load(1, 8);
        alu_op("add", OP_ADD, 2, 0, 1, 4'h1, 4'h1);
        chk("add_hi", hi, 1);
        chk("add_rf2", dut.u_rf.rf_q[2], 1);
        chk("add_count", op_count, 3);

        load(0, 7);
        load(1, 5);
        alu_op("mul", OP_MUL, 3, 0, 1, 4'h3, 4'h2);
        chk("mul_hi", hi, 2);
        alu_op("sub", OP_SUB, 0, 0, 1, 4'h2, 4'h0);
        chk("sub_rf0", dut.u_rf.rf_q[0], 2);
        chk("sub_hi", hi, 0);
        chk("sub_count", op_count, 7);

        send(0, OP_ADD, 2, 0, 1, 0);
        @(posedge clk); #1;
        send_hold: begin
            cmd_load = 1; cmd_rd = 3; cmd_imm = 4'hF; cmd_valid = 1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_x", rsp_x, 7);
            chk("bp_y", rsp_y, 0);
            chk("bp_ready", cmd_ready, 0);
            chk("bp_count", op_count, 7);
            @(posedge clk); #1;
        end
        cmd_valid = 0;
        chk("bp_rf3", dut.u_rf.rf_q[3], 3);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("bp_count_after", op_count, 8);
        chk("bp_idle", cmd_ready, 1);

        load(1, 6);
        send(0, OP_ADD, 1, 0, 1, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4; i++) chk("mid_rst_rf", dut.u_rf.rf_q[i], 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_count", op_count, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_a", a, 0);
        chk("mid_rst_hi", hi, 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", seen, 0);

        load(0, 3);
        load(1, 5);
        alu_op("sub_neg", OP_SUB, 2, 0, 1, 4'hE, 4'h0);
        load(0, 4'hF);
        load(1, 2);
        alu_op("shl", OP_SHL, 2, 0, 1, 4'hC, 4'h3);
        chk("shl_hi", hi, 3);
        chk("shl_opcode", opcode, OP_SHL);
        chk("shl_a", a, 4'hF);
        chk("shl_b", b, 2);
        chk("shl_rf2", dut.u_rf.rf_q[2], 4'hC);
        chk("shl_count", op_count, 6);

        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        cmd_load = 1; cmd_rd = 1; cmd_imm = 4'h5; cmd_valid = 1; rsp_ready = 1;
        acc = 0;
        for (int i = 1; i <= 512; i++) begin
            if (cmd_ready) acc++;
            @(posedge clk); #1;
            if (i == 510) chk("wrap_count_255", op_count, 255);
        end
        cmd_valid = 0; rsp_ready = 0;
        chk("wrap_accepts", acc, 256);
        chk("wrap_count_0", op_count, 0);
        chk("wrap_rf1", dut.u_rf.rf_q[1], 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
